// File: rtl/mem_burst.sv
// rtl/mem_burst.sv - byte-enable RAM with pipelined multi-beat wrapping read bursts
// Optional per-byte parity storage and checking is enabled by defining MEM_PARITY_EN.
module mem_burst #(
    parameter int DWIDTH     = 32,
    parameter int AWIDTH     = 8,
    parameter int RD_LATENCY = 2,
    parameter int BCWIDTH    = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [AWIDTH-1:0]     addr,
    input  logic [DWIDTH-1:0]     data,
    input  logic [DWIDTH/8-1:0]   byteen,
    input  logic                  wr,
    input  logic                  rd,
    input  logic [BCWIDTH-1:0]    burstcount,
    input  logic                  parerr_inject,
    output logic                  waitrequest,
    output logic [DWIDTH-1:0]     rddata,
    output logic                  rddatavalid,
    output logic                  rderr
);
    localparam int NB    = DWIDTH / 8;
    localparam int DEPTH = 1 << AWIDTH;

    typedef enum logic {IDLE, BURST} state_t;

    state_t                state_q, state_d;
    logic [BCWIDTH-1:0]    remain_q, remain_d;
    logic [AWIDTH-1:0]     naddr_q, naddr_d, issue_addr;
    logic                  issue, wait_d, wr_acc;
    logic [DWIDTH-1:0]     rd_word;
    logic                  rd_err;

    logic [DWIDTH-1:0]     mem [DEPTH];

    logic [RD_LATENCY-1:0]             pipe_valid;
    logic [RD_LATENCY-1:0]             pipe_err;
    logic [RD_LATENCY-1:0][DWIDTH-1:0] pipe_data;

    // waitrequest is low exactly when the FSM is idle, so this is the accept rule for writes
    assign wr_acc  = wr && !waitrequest;
    assign rd_word = mem[issue_addr];

    always_comb begin
        state_d    = state_q;
        remain_d   = remain_q;
        naddr_d    = naddr_q;
        wait_d     = 1'b0;
        issue      = 1'b0;
        issue_addr = naddr_q;
        case (state_q)
            IDLE: begin
                if (rd) begin
                    issue      = 1'b1;
                    issue_addr = addr;
                    naddr_d    = addr + AWIDTH'(1);
                    if (burstcount > BCWIDTH'(1)) begin
                        state_d  = BURST;
                        wait_d   = 1'b1;
                        remain_d = burstcount - BCWIDTH'(1);
                    end
                end
            end
            BURST: begin
                issue      = 1'b1;
                issue_addr = naddr_q;
                naddr_d    = naddr_q + AWIDTH'(1);
                remain_d   = remain_q - BCWIDTH'(1);
                if (remain_q == BCWIDTH'(1)) begin
                    state_d = IDLE;
                end else begin
                    wait_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            remain_q    <= '0;
            naddr_q     <= '0;
            waitrequest <= 1'b0;
            pipe_valid  <= '0;
            pipe_err    <= '0;
            pipe_data   <= '0;
        end else begin
            state_q       <= state_d;
            remain_q      <= remain_d;
            naddr_q       <= naddr_d;
            waitrequest   <= wait_d;
            pipe_valid[0] <= issue;
            pipe_err[0]   <= issue && rd_err;
            pipe_data[0]  <= issue ? rd_word : '0;
            for (int i = 1; i < RD_LATENCY; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_err[i]   <= pipe_err[i-1];
                pipe_data[i]  <= pipe_data[i-1];
            end
        end
    end

    // Array contents survive reset; the read in the state block above sees pre-write data
    always_ff @(posedge clk_i) begin
        if (wr_acc) begin
            for (int i = 0; i < NB; i++) begin
                if (byteen[i]) mem[addr][8*i +: 8] <= data[8*i +: 8];
            end
        end
    end

`ifdef MEM_PARITY_EN
    logic [NB-1:0] par_mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (wr_acc) begin
            for (int i = 0; i < NB; i++) begin
                if (byteen[i]) par_mem[addr][i] <= (^data[8*i +: 8]) ^ parerr_inject;
            end
        end
    end

    always_comb begin
        rd_err = 1'b0;
        for (int i = 0; i < NB; i++) begin
            rd_err = rd_err | ((^rd_word[8*i +: 8]) != par_mem[issue_addr][i]);
        end
    end
`else
    logic unused_parerr;
    assign unused_parerr = parerr_inject;
    assign rd_err        = 1'b0;
`endif

    // Pipeline data/err are zeroed on empty slots, so the outputs need no extra gating
    assign rddatavalid = pipe_valid[RD_LATENCY-1];
    assign rddata      = pipe_data[RD_LATENCY-1];
    assign rderr       = pipe_err[RD_LATENCY-1];
endmodule

// File: tb/tb_mem_burst.sv
// tb/tb_mem_burst.sv - scoreboard bench for mem_burst (default parameters)
module tb_mem_burst;
    localparam int L = 2;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [3:0]  byteen;
    logic        wr, rd;
    logic [3:0]  burstcount;
    logic        parerr_inject;
    logic        waitrequest;
    logic [31:0] rddata;
    logic        rddatavalid;
    logic        rderr;

    mem_burst dut (
        .clk_i(clk_i), .rst_i(rst_i), .addr(addr), .data(data), .byteen(byteen),
        .wr(wr), .rd(rd), .burstcount(burstcount), .parerr_inject(parerr_inject),
        .waitrequest(waitrequest), .rddata(rddata), .rddatavalid(rddatavalid), .rderr(rderr)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] d;
        logic        e;
        int          due;
    } beat_t;

    beat_t       sbq[$];
    logic [31:0] model    [256];
    logic [3:0]  model_pe [256];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          beats_seen = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic exp_err(input logic [7:0] a);
`ifdef MEM_PARITY_EN
        return |model_pe[a];
`else
        return 1'b0;
`endif
    endfunction

    task automatic push_beat(input logic [7:0] a, input int due);
        beat_t b;
        b.d   = model[a];
        b.e   = exp_err(a);
        b.due = due;
        sbq.push_back(b);
    endtask

    task automatic model_write(input logic [7:0] a, input logic [31:0] d,
                               input logic [3:0] be, input logic inj);
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                model[a][8*i +: 8] = d[8*i +: 8];
                model_pe[a][i]     = inj;
            end
        end
    endtask

    // Called at posedge+1 with the DUT idle; returns at posedge+1 once waitrequest is low
    task automatic do_cmd(input logic w, input logic r, input logic [7:0] a, input logic [31:0] d,
                          input logic [3:0] be, input logic inj, input logic [3:0] n);
        int nn, acc, wcnt;
        wr = w; rd = r; addr = a; data = d; byteen = be; parerr_inject = inj; burstcount = n;
        @(posedge clk_i); #1;
        acc = cyc;
        wr = 1'b0; rd = 1'b0; parerr_inject = 1'b0;
        nn = (n == 0) ? 1 : int'(n);
        if (r) push_beat(a, acc + L - 1);
        if (w) model_write(a, d, be, inj);
        if (r) begin
            for (int j = 1; j < nn; j++) push_beat(a + 8'(j), acc + j + L - 1);
            wcnt = 0;
            while (waitrequest && wcnt < 40) begin
                wcnt++;
                @(posedge clk_i); #1;
            end
            check_val("wait_cnt", 64'(wcnt), 64'(nn - 1));
        end
    endtask

    task automatic wait_drain();
        int g = 0;
        while (sbq.size() > 0 && g < 100) begin
            g++;
            @(posedge clk_i); #1;
        end
        check_val("drain", 64'(sbq.size()), 64'd0);
    endtask

    initial begin
        beat_t e;
        forever begin
            @(posedge clk_i);
            cyc++;
            #2;
            if (rddatavalid) begin
                if (sbq.size() == 0) begin
                    check_val("unexp_beat", 64'(rddatavalid), 64'd0);
                end else begin
                    e = sbq.pop_front();
                    beats_seen++;
                    check_val("rddata", 64'(rddata), 64'(e.d));
                    check_val("rderr", 64'(rderr), 64'(e.e));
                    check_val("beat_cyc", 64'(cyc), 64'(e.due));
                end
            end else begin
                check_val("idle_out", 64'({rddata, rderr}), 64'd0);
            end
        end
    end

    initial begin
        int base, g, acc;
        rst_i = 1'b1; wr = 1'b0; rd = 1'b0; addr = '0; data = '0; byteen = '0;
        burstcount = '0; parerr_inject = 1'b0;
        for (int i = 0; i < 256; i++) begin
            model[i] = '0;
            model_pe[i] = '0;
        end
        #7;
        check_val("rst_wait", 64'(waitrequest), 64'd0);
        check_val("rst_valid", 64'(rddatavalid), 64'd0);
        check_val("rst_data", 64'(rddata), 64'd0);
        check_val("rst_err", 64'(rderr), 64'd0);
        @(negedge clk_i); rst_i = 1'b0;
        @(posedge clk_i); #1;

        for (int i = 0; i < 256; i++) do_cmd(1, 0, 8'(i), $urandom, 4'hF, 0, 0);

        do_cmd(1, 0, 8'h10, 32'hDEADBEEF, 4'hF, 0, 0);
        do_cmd(1, 0, 8'h10, 32'h11223344, 4'h5, 0, 0);
        do_cmd(0, 1, 8'h10, '0, '0, 0, 4'd1);
        wait_drain();

        do_cmd(1, 0, 8'hFE, 32'hA, 4'hF, 0, 0);
        do_cmd(1, 0, 8'hFF, 32'hB, 4'hF, 0, 0);
        do_cmd(1, 0, 8'h00, 32'hC, 4'hF, 0, 0);
        do_cmd(1, 0, 8'h01, 32'hD, 4'hF, 0, 0);
        do_cmd(0, 1, 8'hFE, '0, '0, 0, 4'd4);
        wait_drain();

        do_cmd(1, 0, 8'h20, 32'h1, 4'hF, 0, 0);
        do_cmd(1, 0, 8'h21, 32'h5555AAAA, 4'hF, 0, 0);
        do_cmd(1, 1, 8'h20, 32'h2, 4'hF, 0, 4'd2);
        do_cmd(0, 1, 8'h20, '0, '0, 0, 4'd1);
        wait_drain();

        do_cmd(0, 1, 8'h50, '0, '0, 0, 4'd3);
        do_cmd(0, 1, 8'h60, '0, '0, 0, 4'd2);
        do_cmd(0, 1, 8'h70, '0, '0, 0, 4'd0);
        wait_drain();

        base = beats_seen;
        rd = 1'b1; addr = 8'h40; burstcount = 4'd8;
        @(posedge clk_i); #1;
        acc = cyc;
        rd = 1'b0;
        for (int j = 0; j < 8; j++) push_beat(8'h40 + 8'(j), acc + j + L - 1);
        g = 0;
        while (beats_seen < base + 3 && g < 40) begin
            g++;
            @(posedge clk_i); #3;
        end
        check_val("third_beat_seen", 64'(beats_seen - base), 64'd3);
        @(negedge clk_i); rst_i = 1'b1;
        #1;
        check_val("midrst_valid", 64'(rddatavalid), 64'd0);
        check_val("midrst_wait", 64'(waitrequest), 64'd0);
        sbq.delete();
        @(negedge clk_i); rst_i = 1'b0;
        repeat (12) @(posedge clk_i);
        #1;
        do_cmd(0, 1, 8'h43, '0, '0, 0, 4'd1);
        wait_drain();

        do_cmd(1, 0, 8'h30, 32'h0F0F1234, 4'hF, 1, 0);
        do_cmd(0, 1, 8'h30, '0, '0, 0, 4'd1);
        do_cmd(1, 0, 8'h31, 32'h87654321, 4'hF, 0, 0);
        do_cmd(0, 1, 8'h31, '0, '0, 0, 4'd1);
        wait_drain();

        for (int k = 0; k < 40; k++) begin
            do_cmd(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom),
                   $urandom, 4'($urandom), 1'($urandom_range(0, 7) == 0),
                   4'($urandom_range(0, 15)));
        end
        wait_drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
